// File: rtl/led_sched_pkg.sv
// Shared types for the status-LED scheduler: FSM encoding, event class IDs, burst lengths.
// Pure declarations; no logic, no latency, no flow control.
package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLASH = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [1:0] ID_OK    = 2'd0;
  localparam logic [1:0] ID_ERR   = 2'd1;
  localparam logic [1:0] ID_ALARM = 2'd2;
  localparam logic [1:0] ID_NONE  = 2'd3;

  localparam int NUM_CLASSES = 3;

  // Burst length for a class; counts come from the instantiating module's parameters.
  function automatic int unsigned toggles(input logic [1:0]  id,
                                          input int unsigned ok_t,
                                          input int unsigned err_t,
                                          input int unsigned alarm_t);
    case (id)
      ID_OK:    return ok_t;
      ID_ERR:   return err_t;
      ID_ALARM: return alarm_t;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/led_req_pending.sv
// Pending-request flops (set wins over grant-clear) plus a fixed-priority encoder (2>1>0).
// Request visible one edge after the pulse; no backpressure, requests are never lost.
module led_req_pending
  import led_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CLASSES-1:0] req,
  input  logic                   grant,
  input  logic [1:0]             grant_id,
  output logic [NUM_CLASSES-1:0] pending,
  output logic                   any,
  output logic [1:0]             top_id
);

  logic [NUM_CLASSES-1:0] clr_mask;

  always_comb begin
    clr_mask = '0;
    if (grant) begin
      clr_mask = NUM_CLASSES'(3'b001 << grant_id);
    end
  end

  // A request arriving in its own grant cycle re-arms the bit so the event replays.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | req;
    end
  end

  always_comb begin
    any    = |pending;
    top_id = ID_NONE;
    if (pending[2]) begin
      top_id = ID_ALARM;
    end else if (pending[1]) begin
      top_id = ID_ERR;
    end else if (pending[0]) begin
      top_id = ID_OK;
    end
  end

endmodule

// File: rtl/led_event_scheduler.sv
// Shares one status LED between OK/ERR/ALARM events: prioritised, preemptive, tick-paced blink bursts.
// Grant one edge after pending; no backpressure. LED_ALARM_LATCH_EN: alarm blinks until alarm_clr.
module led_event_scheduler
  import led_sched_pkg::*;
#(
  parameter int OK_TOGGLES    = 4,
  parameter int ERR_TOGGLES   = 8,
  parameter int ALARM_TOGGLES = 16,
  parameter int CNT_W         = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [2:0] req,
  input  logic       alarm_clr,
  output logic       led,
  output logic       busy,
  output logic [1:0] active_id,
  output logic       done
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               led_q, led_d;
  logic [1:0]         id_q, id_d;
  logic               done_q, done_d;

  logic               grant;
  logic [2:0]         pending;
  logic               any;
  logic [1:0]         top_id;
  logic               preempt;
  logic [CNT_W-1:0]   load_cnt;

  led_req_pending u_pending (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .grant    (grant),
    .grant_id (top_id),
    .pending  (pending),
    .any      (any),
    .top_id   (top_id)
  );

  assign load_cnt = CNT_W'(toggles(top_id, OK_TOGGLES, ERR_TOGGLES, ALARM_TOGGLES));
  assign preempt  = any && (top_id > id_q);

`ifndef LED_ALARM_LATCH_EN
  logic unused_alarm_clr;
  assign unused_alarm_clr = alarm_clr;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    id_d    = id_q;
    done_d  = 1'b0;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          grant   = 1'b1;
          state_d = FLASH;
          cnt_d   = load_cnt;
          led_d   = 1'b0;
          id_d    = top_id;
        end
      end
      FLASH: begin
        // The aborted burst is dropped outright: no done, no requeue, no gap.
        if (preempt) begin
          grant   = 1'b1;
          cnt_d   = load_cnt;
          led_d   = 1'b0;
          id_d    = top_id;
`ifdef LED_ALARM_LATCH_EN
        end else if (id_q == ID_ALARM) begin
          if (alarm_clr) begin
            led_d   = 1'b0;
            state_d = GAP;
          end else if (tick) begin
            led_d = ~led_q;
          end
`endif
        end else if (tick) begin
          if (cnt_q != '0) begin
            led_d = ~led_q;
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            led_d   = 1'b0;
            done_d  = 1'b1;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        led_d = 1'b0;
        if (tick) begin
          state_d = IDLE;
          id_d    = ID_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        led_d   = 1'b0;
        id_d    = ID_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      led_q   <= 1'b0;
      id_q    <= ID_NONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      id_q    <= id_d;
      done_q  <= done_d;
    end
  end

  assign led       = led_q;
  assign busy      = (state_q != IDLE);
  assign active_id = id_q;
  assign done      = done_q;

endmodule

// File: tb/tb_led_event_scheduler.sv
// Directed bench for led_event_scheduler: bursts, priority, preemption, replay, async reset.
// Alarm-latch scenario only in builds with LED_ALARM_LATCH_EN.
module tb_led_event_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [2:0] req;
  logic       alarm_clr;
  logic       led;
  logic       busy;
  logic [1:0] active_id;
  logic       done;

  int          checks = 0;
  int          errors = 0;
  int          toggles = 0;
  int          dones = 0;
  logic        led_prev = 1'b0;
  logic [31:0] led_hist = '0;
  logic        tick_en = 1'b0;

  int t0, t1, d0, bz;
  bit ok;

  led_event_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .req       (req),
    .alarm_clr (alarm_clr),
    .led       (led),
    .busy      (busy),
    .active_id (active_id),
    .done      (done)
  );

  always #5 clk = ~clk;

  // One-cycle tick every 10 clocks while enabled.
  initial begin
    tick = 1'b0;
    forever begin
      repeat (9) @(posedge clk);
      #1 tick = tick_en;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) dones <= dones + 1;
    if (led !== led_prev) begin
      toggles  <= toggles + 1;
      led_hist <= {led_hist[30:0], led};
    end
    led_prev <= led;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse(input logic [2:0] r);
    req = r;
    cyc(1);
    req = 3'b000;
  endtask

  task automatic wait_busy(input int max, output bit okk);
    okk = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (busy === 1'b1) begin okk = 1'b1; break; end
      cyc(1);
    end
  endtask

  task automatic wait_idle(input int max, output bit okk);
    okk = 1'b0;
    for (int i = 0; i < max; i++) begin
      cyc(1);
      if (busy === 1'b0) begin okk = 1'b1; break; end
    end
  endtask

  task automatic wait_done(input int max, output bit okk);
    okk = 1'b0;
    for (int i = 0; i < max; i++) begin
      cyc(1);
      if (done === 1'b1) begin okk = 1'b1; break; end
    end
  endtask

  task automatic wait_toggles(input int base, input int n, input int max, output bit okk);
    okk = 1'b0;
    for (int i = 0; i < max; i++) begin
      cyc(1);
      if (toggles - base >= n) begin okk = 1'b1; break; end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 3'b000;
    alarm_clr = 1'b0;
    #12;
    check("rst_led", led, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_active_id", active_id, 2'd3);
    check("rst_done", done, 1'b0);
    check("rst_pending", dut.u_pending.pending, 3'b000);
    rst_n = 1'b1;
    cyc(2);
    tick_en = 1'b1;

    // 1: single OK burst
    t0 = toggles; d0 = dones;
    pulse(3'b001);
    check("t1_pending_set", dut.u_pending.pending, 3'b001);
    check("t1_busy_before_grant", busy, 1'b0);
    cyc(1);
    check("t1_busy_grant", busy, 1'b1);
    check("t1_active_id", active_id, 2'd0);
    check("t1_led_grant", led, 1'b0);
    check("t1_pending_clr", dut.u_pending.pending, 3'b000);
    wait_done(100, ok);
    check("t1_done_seen", ok, 1'b1);
    check("t1_toggles", toggles - t0, 4);
    check("t1_pattern", led_hist[3:0], 4'b1010);
    check("t1_gap_led", led, 1'b0);
    check("t1_gap_busy", busy, 1'b1);
    wait_idle(15, ok);
    check("t1_idle_seen", ok, 1'b1);
    check("t1_idle_id", active_id, 2'd3);
    check("t1_done_count", dones - d0, 1);

    // 2: simultaneous ERR and OK, ERR first
    t0 = toggles; d0 = dones;
    pulse(3'b011);
    cyc(1);
    check("t2_first_id", active_id, 2'd1);
    wait_done(200, ok);
    check("t2_err_done", ok, 1'b1);
    check("t2_err_toggles", toggles - t0, 8);
    wait_idle(15, ok);
    check("t2_gap_end", ok, 1'b1);
    wait_busy(5, ok);
    check("t2_second_grant", ok, 1'b1);
    check("t2_second_id", active_id, 2'd0);
    t1 = toggles;
    wait_done(100, ok);
    check("t2_ok_done", ok, 1'b1);
    check("t2_ok_toggles", toggles - t1, 4);
    wait_idle(15, ok);
    check("t2_done_count", dones - d0, 2);

`ifndef LED_ALARM_LATCH_EN
    // 3: alarm preempts OK after two toggles
    t0 = toggles; d0 = dones;
    pulse(3'b001);
    cyc(1);
    check("t3_ok_id", active_id, 2'd0);
    wait_toggles(t0, 2, 60, ok);
    check("t3_two_toggles", ok, 1'b1);
    pulse(3'b100);
    cyc(1);
    check("t3_preempt_led", led, 1'b0);
    check("t3_preempt_id", active_id, 2'd2);
    t1 = toggles;
    wait_done(300, ok);
    check("t3_alarm_done", ok, 1'b1);
    check("t3_alarm_toggles", toggles - t1, 16);
    wait_idle(15, ok);
    check("t3_done_count", dones - d0, 1);
    check("t3_pending_empty", dut.u_pending.pending, 3'b000);
`endif

    // 4: ERR re-requested during its own burst replays after the gap
    t0 = toggles; d0 = dones;
    pulse(3'b010);
    cyc(1);
    check("t4_id", active_id, 2'd1);
    wait_toggles(t0, 3, 60, ok);
    check("t4_three_toggles", ok, 1'b1);
    pulse(3'b010);
    check("t4_requeued", dut.u_pending.pending, 3'b010);
    wait_done(200, ok);
    check("t4_first_done", ok, 1'b1);
    check("t4_first_toggles", toggles - t0, 8);
    wait_idle(15, ok);
    wait_busy(5, ok);
    check("t4_replay_grant", ok, 1'b1);
    check("t4_replay_id", active_id, 2'd1);
    t1 = toggles;
    wait_done(200, ok);
    check("t4_replay_toggles", toggles - t1, 8);
    wait_idle(15, ok);
    check("t4_done_count", dones - d0, 2);

    // 5: async reset mid-burst
    t0 = toggles;
    pulse(3'b010);
    cyc(1);
    wait_toggles(t0, 3, 60, ok);
    check("t5_cnt_five", dut.cnt_q, 5);
    pulse(3'b001);
    #1 rst_n = 1'b0;
    #1;
    check("t5_led", led, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_active_id", active_id, 2'd3);
    check("t5_pending", dut.u_pending.pending, 3'b000);
    cyc(3);
    rst_n = 1'b1;
    bz = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (busy !== 1'b0) bz++;
    end
    check("t5_no_burst", bz, 0);

`ifdef LED_ALARM_LATCH_EN
    // 6: latched alarm runs until cleared, lower request waits
    t0 = toggles; d0 = dones;
    pulse(3'b100);
    cyc(1);
    check("t6_alarm_id", active_id, 2'd2);
    pulse(3'b001);
    wait_toggles(t0, 40, 450, ok);
    check("t6_forty_toggles", ok, 1'b1);
    check("t6_no_done", dones - d0, 0);
    check("t6_still_busy", busy, 1'b1);
    check("t6_still_alarm", active_id, 2'd2);
    alarm_clr = 1'b1;
    cyc(1);
    alarm_clr = 1'b0;
    check("t6_clr_led", led, 1'b0);
    check("t6_clr_gap", busy, 1'b1);
    wait_idle(15, ok);
    check("t6_gap_end", ok, 1'b1);
    wait_busy(5, ok);
    check("t6_ok_grant", ok, 1'b1);
    check("t6_ok_id", active_id, 2'd0);
    t1 = toggles;
    wait_done(100, ok);
    check("t6_ok_toggles", toggles - t1, 4);
    wait_idle(15, ok);
    check("t6_done_count", dones - d0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
